// File: rtl/mem_block_server_pkg.sv
// mem_block_server_pkg: shared widths and FSM encoding for the block server.
package mem_block_server_pkg;
  localparam int WORD_SIZE = 32;
  localparam int BLOCK_SIZE = 4;
  localparam int BLOCK_BITS = WORD_SIZE * BLOCK_SIZE;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE * WORD_SIZE / 8);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } state_e;
endpackage

// File: rtl/mem_block_server_if.sv
// mem_block_server_if: block request and response handshakes between cache and server.
interface mem_block_server_if;
  import mem_block_server_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [WORD_SIZE-1:0] req_addr;
  logic [BLOCK_BITS-1:0] req_wdata;
  logic resp_valid;
  logic resp_ready;
  logic [BLOCK_BITS-1:0] resp_rdata;
  logic resp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_block_server_block_mem_array.sv
// block_mem_array: single-port word array, synchronous read and write, zero at power-up.
module block_mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_block_server.sv
// mem_block_server: serves block reads/writes from a backing word array after a fixed latency.
module mem_block_server
  import mem_block_server_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  mem_block_server_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(BLOCK_SIZE);
  localparam int BW = WORD_SIZE - OFFSET_BITS;
  localparam int IW = BW + CW;
  localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [BW-1:0] blk_q, blk_d, req_blk;
  logic [BLOCK_BITS-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata, mem_rdata;
  assign req_blk = BW'(bus.req_addr >> OFFSET_BITS);
  // Reads fetch one word ahead so word k is in mem_rdata during XFER cycle k.
  assign mem_addr = AW'(st_q == IDLE ? {req_blk, CW'(0)}
                                     : {blk_q, cnt_q} + IW'(st_q == XFER && !wr_q));
  assign mem_we = st_q == XFER && wr_q && !err_q;
  assign mem_wdata = wdata_q[cnt_q*WORD_SIZE +: WORD_SIZE];
  assign bus.req_ready = st_q == IDLE;
  assign bus.resp_valid = st_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err = err_q;
  block_mem_array #(.WIDTH(WORD_SIZE), .DEPTH(MEM_WORDS)) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    wr_d = wr_q;
    err_d = err_q;
    blk_d = blk_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (st_q)
      IDLE: if (bus.req_valid) begin
        st_d = LATENCY == 0 ? XFER : WAIT;
        cnt_d = '0;
        lat_d = '0;
        wr_d = bus.req_write;
        err_d = 32'(req_blk) >= MEM_WORDS / BLOCK_SIZE;
        blk_d = req_blk;
        wdata_d = bus.req_wdata;
        rdata_d = '0;
      end
      WAIT: begin
        lat_d = lat_q + LW'(1);
        st_d = lat_q == LW'(LATENCY - 1) ? XFER : WAIT;
      end
      XFER: begin
        cnt_d = cnt_q + CW'(1);
        if (!wr_q && !err_q) rdata_d[cnt_q*WORD_SIZE +: WORD_SIZE] = mem_rdata;
        st_d = cnt_q == CW'(BLOCK_SIZE - 1) ? RESP : XFER;
      end
      default: st_d = bus.resp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      lat_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      blk_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      wr_q <= wr_d;
      err_q <= err_d;
      blk_q <= blk_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_block_server.sv
// tb_mem_block_server: randomized scoreboard bench for a LATENCY=2 and a LATENCY=0 server.
module tb_mem_block_server;
  import mem_block_server_pkg::*;
  localparam int MW = 4096;
  localparam int MW0 = 64;
  typedef struct packed {
    logic [BLOCK_BITS-1:0] rdata;
    logic err;
  } resp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic z = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [WORD_SIZE-1:0] req_addr = '0;
  logic [BLOCK_BITS-1:0] req_wdata = '0;
  logic c_valid, c_rdy, c_err;
  logic [BLOCK_BITS-1:0] c_rdata;
  logic [WORD_SIZE-1:0] m [MW];
  logic [WORD_SIZE-1:0] m0 [MW0];
  resp_t q[$];
  int checks = 0;
  int failures = 0;

  mem_block_server_if bus ();
  mem_block_server_if bus0 ();
  mem_block_server #(.MEM_WORDS(MW), .LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  mem_block_server #(.MEM_WORDS(MW0), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  assign bus.req_valid = req_valid && !z;
  assign bus0.req_valid = req_valid && z;
  assign bus.req_write = req_write;
  assign bus0.req_write = req_write;
  assign bus.req_addr = req_addr;
  assign bus0.req_addr = req_addr;
  assign bus.req_wdata = req_wdata;
  assign bus0.req_wdata = req_wdata;
  assign bus.resp_ready = resp_ready;
  assign bus0.resp_ready = resp_ready;
  assign c_valid = z ? bus0.resp_valid : bus.resp_valid;
  assign c_rdy = z ? bus0.req_ready : bus.req_ready;
  assign c_err = z ? bus0.resp_err : bus.resp_err;
  assign c_rdata = z ? bus0.resp_rdata : bus.resp_rdata;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [BLOCK_BITS-1:0] act, input logic [BLOCK_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model works on whole blocks; nw words of a write are considered committed.
  task automatic issue(input logic w, input logic [WORD_SIZE-1:0] a, input logic [BLOCK_BITS-1:0] d,
                       input int nw, input bit push);
    int b, idx;
    resp_t e;
    b = int'(a >> OFFSET_BITS);
    e.err = (b + 1) * BLOCK_SIZE > (z ? MW0 : MW);
    e.rdata = '0;
    if (!e.err)
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        idx = b * BLOCK_SIZE + k;
        if (w && k < nw) begin
          if (z) m0[idx] = d[k*WORD_SIZE +: WORD_SIZE];
          else m[idx] = d[k*WORD_SIZE +: WORD_SIZE];
        end else if (!w) e.rdata[k*WORD_SIZE +: WORD_SIZE] = z ? m0[idx] : m[idx];
      end
    if (push) q.push_back(e);
    chk("req_ready_idle", c_rdy, 1);
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr = $urandom;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic complete(input int bp);
    int n;
    logic [BLOCK_BITS-1:0] snap;
    n = 0;
    while (!c_valid && n < 40) begin
      tick();
      n++;
    end
    chk("latency", n, z ? 4 : 6);
    snap = c_rdata;
    repeat (bp) begin
      tick();
      chk("bp_valid", c_valid, 1);
      chk("bp_rdata_stable", c_rdata, snap);
      chk("bp_req_ready", c_rdy, 0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("req_ready_after_hs", c_rdy, 1);
    chk("valid_after_hs", c_valid, 0);
  endtask

  task automatic rnd_txn();
    int blk;
    logic [WORD_SIZE-1:0] a;
    blk = $urandom_range(0, 15);
    if ($urandom_range(0, 7) == 0) blk = (z ? MW0 : MW) / BLOCK_SIZE - 1 + $urandom_range(0, 1);
    a = WORD_SIZE'(blk << OFFSET_BITS) | WORD_SIZE'($urandom_range(0, 15));
    issue(1'($urandom), a, {$urandom, $urandom, $urandom, $urandom}, BLOCK_SIZE, 1);
    complete($urandom_range(0, 3));
  endtask

  always @(negedge clk) begin : monitor
    resp_t e;
    if (!rst && c_valid && resp_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%h required=none", c_rdata);
      end else begin
        e = q.pop_front();
        chk("resp_rdata", c_rdata, e.rdata);
        chk("resp_err", c_err, e.err);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    foreach (m[i]) m[i] = '0;
    foreach (m0[i]) m0[i] = '0;
    tick();
    tick();
    chk("rst_req_ready", c_rdy, 1);
    chk("rst_resp_valid", c_valid, 0);
    chk("rst_resp_rdata", c_rdata, 0);
    chk("rst_resp_err", c_err, 0);
    req_valid = 1'b1;
    req_addr = 32'h40;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (8) tick();
    chk("req_ignored_in_rst", c_valid, 0);
    chk("idle_after_rst", c_rdy, 1);
    issue(1, 32'h40, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, BLOCK_SIZE, 1);
    complete(0);
    issue(0, 32'h4C, '0, BLOCK_SIZE, 1);
    complete(5);
    issue(0, MW * 4, '0, BLOCK_SIZE, 1);
    complete(0);
    issue(1, MW * 4, {4{32'hDEADBEEF}}, BLOCK_SIZE, 1);
    complete(1);
    issue(0, MW * 4 - 16, '0, BLOCK_SIZE, 1);
    complete(0);
    issue(0, 32'hFFFF_FFF0, '0, BLOCK_SIZE, 1);
    complete(0);
    issue(1, 32'h80, {4{32'hAAAAAAAA}}, 2, 0);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", c_rdy, 1);
    chk("midrst_resp_valid", c_valid, 0);
    chk("midrst_resp_rdata", c_rdata, 0);
    chk("midrst_resp_err", c_err, 0);
    tick();
    rst = 1'b0;
    tick();
    issue(0, 32'h80, '0, BLOCK_SIZE, 1);
    complete(0);
    repeat (40) rnd_txn();
    z = 1'b1;
    issue(0, 32'h0, '0, BLOCK_SIZE, 1);
    complete(0);
    issue(1, 32'h10, {$urandom, $urandom, $urandom, $urandom}, BLOCK_SIZE, 1);
    complete(0);
    issue(0, 32'h10, '0, BLOCK_SIZE, 1);
    complete(2);
    issue(0, MW0 * 4, '0, BLOCK_SIZE, 1);
    complete(0);
    repeat (15) rnd_txn();
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
